// File: rtl/ahbl_wrr_sched.sv
// Weighted round-robin grant scheduler for an N:1 AHB-Lite arbiter.
// Produces a combinational address-phase grant and a registered data-phase grant, honouring HMASTLOCK.
module ahbl_wrr_sched #(
    parameter int N_PORTS        = 4,
    parameter int W_CREDIT       = 4,
    parameter int DEFAULT_WEIGHT = 1,
    localparam int IDX_W         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_PORTS-1:0]  req,
    input  logic [N_PORTS-1:0]  lock,
    input  logic                dst_hready,
    input  logic                cfg_wen,
    input  logic [IDX_W-1:0]    cfg_port,
    input  logic [W_CREDIT-1:0] cfg_weight,
    output logic [N_PORTS-1:0]  gnt_a,
    output logic [N_PORTS-1:0]  gnt_d,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic                locked
);

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_PORTS - 1);
    localparam logic [IDX_W:0]      PORT_LIM = (IDX_W + 1)'(N_PORTS);
    localparam logic [W_CREDIT-1:0] RST_WGT  = W_CREDIT'(DEFAULT_WEIGHT);

    logic [W_CREDIT-1:0] weight_q [N_PORTS];
    logic [W_CREDIT-1:0] weight_d [N_PORTS];
    logic [W_CREDIT-1:0] credit_q [N_PORTS];
    logic [W_CREDIT-1:0] credit_d [N_PORTS];
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    ptr_d;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    owner_d;
    logic                lock_hold_q;
    logic                lock_hold_d;
    logic [N_PORTS-1:0]  gnt_d_q;
    logic [N_PORTS-1:0]  gnt_d_d;

    logic [N_PORTS-1:0]  eligible_s;
    logic [N_PORTS-1:0]  avail_s;
    logic                lock_act_s;
    logic                sel_valid_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic                reload_s;
    logic [N_PORTS-1:0]  gnt_a_s;
    logic [W_CREDIT-1:0] g_credit_s;
    logic                cfg_hit_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    // Returns {found, index} of the first set mask bit scanning cyclically from start.
    function automatic logic [IDX_W:0] scan_from(input logic [N_PORTS-1:0] mask,
                                                 input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        idx   = start;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && mask[idx]) begin
                found = 1'b1;
                res   = idx;
            end else begin
                found = found;
            end
            idx = next_idx(idx);
        end
        return {found, res};
    endfunction

    // Per-port eligibility and credit availability.
    always_comb begin
        eligible_s = '0;
        avail_s    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            eligible_s[i] = req[i] && (weight_q[i] != '0);
            avail_s[i]    = eligible_s[i] && (credit_q[i] != '0);
        end
    end

    assign lock_act_s = lock_hold_q && req[owner_q];

    // Grant selection: locked owner, then credited ports, then replenish.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        reload_s    = 1'b0;
        if (lock_act_s) begin
            sel_valid_s = 1'b1;
            sel_idx_s   = owner_q;
        end else if (|avail_s) begin
            {sel_valid_s, sel_idx_s} = scan_from(avail_s, ptr_q);
        end else if (|eligible_s) begin
            {sel_valid_s, sel_idx_s} = scan_from(eligible_s, ptr_q);
            reload_s = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // One-hot decode of the selected port.
    always_comb begin
        gnt_a_s = '0;
        if (sel_valid_s) begin
            gnt_a_s[sel_idx_s] = 1'b1;
        end else begin
            gnt_a_s = '0;
        end
    end

    assign cfg_hit_s = cfg_wen && ({1'b0, cfg_port} < PORT_LIM);

    // Next-state: handoff bookkeeping, then config write overrides its own port.
    always_comb begin
        weight_d    = weight_q;
        credit_d    = credit_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        lock_hold_d = lock_hold_q;
        gnt_d_d     = gnt_d_q;
        g_credit_s  = '0;
        if (dst_hready) begin
            gnt_d_d = gnt_a_s;
            if (sel_valid_s) begin
                if (reload_s) begin
                    for (int i = 0; i < N_PORTS; i++) begin
                        credit_d[i] = weight_q[i];
                    end
                    g_credit_s = weight_q[sel_idx_s] - W_CREDIT'(1);
                end else if (credit_q[sel_idx_s] != '0) begin
                    g_credit_s = credit_q[sel_idx_s] - W_CREDIT'(1);
                end else begin
                    // Locked grant at zero credit saturates rather than wrapping.
                    g_credit_s = '0;
                end
                credit_d[sel_idx_s] = g_credit_s;
                if (g_credit_s != '0) begin
                    ptr_d = sel_idx_s;
                end else begin
                    ptr_d = next_idx(sel_idx_s);
                end
                lock_hold_d = lock[sel_idx_s];
                owner_d     = sel_idx_s;
            end else begin
                lock_hold_d = 1'b0;
            end
        end else begin
            gnt_d_d = gnt_d_q;
        end
        if (cfg_hit_s) begin
            weight_d[cfg_port] = cfg_weight;
            credit_d[cfg_port] = cfg_weight;
        end else begin
            weight_d[0] = weight_d[0];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PORTS; i++) begin
                weight_q[i] <= RST_WGT;
                credit_q[i] <= RST_WGT;
            end
            ptr_q       <= '0;
            owner_q     <= '0;
            lock_hold_q <= 1'b0;
            gnt_d_q     <= '0;
        end else begin
            weight_q    <= weight_d;
            credit_q    <= credit_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            lock_hold_q <= lock_hold_d;
            gnt_d_q     <= gnt_d_d;
        end
    end

    assign gnt_a   = gnt_a_s;
    assign gnt_idx = sel_idx_s;
    assign gnt_d   = gnt_d_q;
    assign locked  = lock_act_s;

endmodule

// File: tb/tb_ahbl_wrr_sched.sv
// Directed self-checking bench for ahbl_wrr_sched (N_PORTS=4, weights default 1).
module tb_ahbl_wrr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       dst_hready;
    logic       cfg_wen;
    logic [1:0] cfg_port;
    logic [3:0] cfg_weight;
    logic [3:0] gnt_a;
    logic [3:0] gnt_d;
    logic [1:0] gnt_idx;
    logic       locked;

    int n_cmp;
    int n_err;

    ahbl_wrr_sched #(
        .N_PORTS(4),
        .W_CREDIT(4),
        .DEFAULT_WEIGHT(1)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .lock(lock),
        .dst_hready(dst_hready),
        .cfg_wen(cfg_wen),
        .cfg_port(cfg_port),
        .cfg_weight(cfg_weight),
        .gnt_a(gnt_a),
        .gnt_d(gnt_d),
        .gnt_idx(gnt_idx),
        .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] p, input logic [3:0] w);
        cfg_wen    = 1'b1;
        cfg_port   = p;
        cfg_weight = w;
        cyc();
        cfg_wen    = 1'b0;
    endtask

    int exp_wrr[12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
    int exp_rl[7]   = '{2, 2, 0, 0, 2, 2, 0};

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req        = 4'b0000;
        lock       = 4'b0000;
        dst_hready = 1'b1;
        cfg_wen    = 1'b0;
        cfg_port   = 2'd0;
        cfg_weight = 4'd0;

        #3;
        chk("rst_gnt_a", 32'(gnt_a), 32'h0);
        chk("rst_gnt_d", 32'(gnt_d), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Equal weights: plain round robin with gnt_d one handoff behind.
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #2;
            chk("rr_gnt_a", 32'(gnt_a), 32'd1 << (c % 4));
            chk("rr_gnt_d", 32'(gnt_d), (c == 0) ? 32'h0 : (32'd1 << ((c - 1) % 4)));
            cyc();
        end

        // Weights {3,1,0,2}.
        req = 4'b0000;
        cfg_write(2'd0, 4'd3);
        cfg_write(2'd1, 4'd1);
        cfg_write(2'd2, 4'd0);
        cfg_write(2'd3, 4'd2);
        req = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            #2;
            chk("wrr_idx", 32'(gnt_idx), 32'(exp_wrr[c]));
            cyc();
        end

        // Stall: gnt_d and credits frozen while req toggles.
        dst_hready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req = (k % 2 == 0) ? 4'b0011 : 4'b0110;
            #2;
            chk("stall_gnt_d", 32'(gnt_d), 32'h8);
            chk("stall_gnt_a", 32'(gnt_a), (k % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
        end
        req        = 4'b0110;
        dst_hready = 1'b1;
        #2;
        chk("resume_gnt_a", 32'(gnt_a), 32'h2);
        cyc();
        req = 4'b1111;
        #2;
        chk("resume_gnt_d", 32'(gnt_d), 32'h2);
        chk("resume_next", 32'(gnt_a), 32'h8);
        cyc();

        // Locked sequence on port 1.
        req = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            cfg_write(2'(p), 4'd1);
        end
        req  = 4'b0010;
        lock = 4'b0010;
        #2;
        chk("lk_first", 32'(gnt_a), 32'h2);
        chk("lk_first_locked", 32'(locked), 32'h0);
        cyc();
        req        = 4'b0011;
        cfg_wen    = 1'b1;
        cfg_port   = 2'd1;
        cfg_weight = 4'd0;
        #2;
        chk("lk_hold", 32'(gnt_a), 32'h2);
        chk("lk_hold_locked", 32'(locked), 32'h1);
        cyc();
        cfg_wen = 1'b0;
        lock    = 4'b0000;
        #2;
        chk("lk_w0_hold", 32'(gnt_a), 32'h2);
        chk("lk_w0_locked", 32'(locked), 32'h1);
        cyc();
        #2;
        chk("lk_release", 32'(gnt_a), 32'h1);
        chk("lk_release_locked", 32'(locked), 32'h0);
        chk("lk_release_gnt_d", 32'(gnt_d), 32'h2);
        cyc();

        // Weights 2, req=0101: reload happens without an idle cycle.
        req = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            cfg_write(2'(p), 4'd2);
        end
        req = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            #2;
            chk("reload_idx", 32'(gnt_a), 32'd1 << exp_rl[c]);
            cyc();
        end
        #2;
        chk("reload_last", 32'(gnt_a), 32'd1 << exp_rl[6]);
        chk("pre_rst_gnt_d", 32'(gnt_d), 32'h4);

        // Asynchronous reset mid-transfer.
        rst_n = 1'b0;
        #1;
        chk("arst_gnt_d", 32'(gnt_d), 32'h0);
        req = 4'b1111;
        #1;
        chk("arst_gnt_a", 32'(gnt_a), 32'h1);
        cyc();
        rst_n = 1'b1;
        #2;
        chk("post_rst_first", 32'(gnt_a), 32'h1);
        cyc();
        #2;
        chk("post_rst_second", 32'(gnt_a), 32'h2);
        chk("post_rst_gnt_d", 32'(gnt_d), 32'h1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
